// File: rtl/esn_pkg.sv
// Shared definitions for the ESN receive path: default frame geometry,
// framer state encoding and an index-width helper.
package esn_pkg;

  // Samples per ESN input frame and signed sample width (two bytes per sample).
  localparam int NUM_IN_DEF = 20;
  localparam int DATA_W_DEF = 16;

  // Framer state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  // Width of an index that counts 0..n-1.
  // Never returns 0, so a one-entry store still gets a legal 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/esn_rx_wordbuf.sv
// Sample store for one ESN input frame.
// Writes one byte lane per cycle. Reads one whole sample combinationally.
module esn_rx_wordbuf
  import esn_pkg::*;
#(
  parameter int DEPTH  = NUM_IN_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_lo,
  input  logic [7:0]        wr_byte,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write: high byte first (big-endian), then low byte.
  // NOTE: the storage has no reset on purpose. Every entry is rewritten
  // before a frame is delivered, so a reset would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_lo) mem[wr_addr][7:0]          <= wr_byte;
      else       mem[wr_addr][DATA_W-1 -: 8] <= wr_byte;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/esn_rx_framer.sv
// Turns UDP payload bytes from the temac rx FIFO into a frame of NUM_IN
// signed samples for the ESN core.
// Short frames are counted and dropped.
// Bytes beyond the frame length are drained up to tlast.
module esn_rx_framer
  import esn_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  input  logic                     udp_payload,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               err_cnt,
  output logic                     err_pulse
);

  localparam int RW = idx_w(NUM_IN);
  localparam int BW = RW + 1;
  localparam logic [BW-1:0] LAST_B = BW'(2 * NUM_IN - 1);
  localparam logic [RW-1:0] LAST_R = RW'(NUM_IN - 1);

  logic [1:0]        state;
  logic [BW-1:0]     byte_idx;
  logic [RW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              byte_hs;
  logic              pl_hs;
  logic              out_hs;
  logic              term_byte;
  logic              short_end;
  logic              frame_done;

  assign s_tready = (state != ST_OUT);
  assign byte_hs  = s_tvalid & s_tready;
  assign pl_hs    = byte_hs & udp_payload;
  assign m_valid  = (state == ST_OUT);
  assign out_hs   = m_valid & m_ready;

  // The payload byte that completes a frame.
  assign term_byte = pl_hs & (state == ST_COLLECT) & (byte_idx == LAST_B);

  // tlast arriving before the frame is complete.
  // In IDLE this needs a payload byte; a lone tlast there is ignored.
  assign short_end = byte_hs & s_tlast & ~term_byte &
                     (((state == ST_IDLE) & udp_payload) | (state == ST_COLLECT));

  assign frame_done = out_hs & (rd_idx == LAST_R);

  // Outputs read as zero whenever no sample is offered.
  assign m_data = m_valid ? rd_data : '0;
  assign m_last = m_valid & (rd_idx == LAST_R);

  esn_rx_wordbuf #(
    .DEPTH  (NUM_IN),
    .DATA_W (DATA_W),
    .AW     (RW)
  ) u_wordbuf (
    .clk     (clk),
    .wr_en   (pl_hs & ((state == ST_IDLE) | (state == ST_COLLECT))),
    .wr_addr (byte_idx[BW-1:1]),
    .wr_lo   (byte_idx[0]),
    .wr_byte (s_tdata),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // Frame state machine: collect payload, drain overlong frames, deliver samples.
  // NOTE: every register in a clocked block uses <=, so each register samples
  // the values from before the edge. The order of statements then has no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      rd_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pl_hs && !s_tlast) begin
            byte_idx <= BW'(1);
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (term_byte) begin
            byte_idx <= '0;
            state    <= s_tlast ? ST_OUT : ST_DRAIN;
          end else if (short_end) begin
            byte_idx <= '0;
            state    <= ST_IDLE;
          end else if (pl_hs) begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (byte_hs && s_tlast) state <= ST_OUT;
        end
        ST_OUT: begin
          if (frame_done) begin
            rd_idx <= '0;
            state  <= ST_IDLE;
          end else if (out_hs) begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Short-frame statistics: single-cycle pulse plus a saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= short_end;
      if (short_end && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Good-frame count, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_esn_rx_framer.sv
// Self-checking bench for esn_rx_framer.
// Each frame is built as a byte list. A reference model derives the outcome
// from payload-byte counts: dropped, short, or good with the expected samples.
module tb_esn_rx_framer;

  localparam int N  = 20;
  localparam int NB = 2 * N;

  typedef struct {
    logic [7:0] d;
    logic       pl;
    logic       last;
  } byte_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic        udp_payload;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;
  int model_frames = 0;
  int model_errs = 0;

  byte_t       frame_q[$];
  logic [15:0] exp_q[$];

  esn_rx_framer #(.NUM_IN(N), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .udp_payload (udp_payload),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    udp_payload = 1'b0;
    s_tdata     = 8'h00;
  endtask

  // Build a frame: headers, payload (sequential or random, optional interleaved
  // non-payload junk), trailing headers, tlast on the final byte if requested.
  task automatic build(input int n_hdr, input int n_pl, input bit seq,
                       input int n_tail, input bit junk, input bit with_last);
    byte_t b;
    frame_q.delete();
    for (int i = 0; i < n_hdr; i++) begin
      b.d = 8'($urandom); b.pl = 1'b0; b.last = 1'b0; frame_q.push_back(b);
    end
    for (int i = 0; i < n_pl; i++) begin
      if (junk && $urandom_range(0, 5) == 0) begin
        b.d = 8'($urandom); b.pl = 1'b0; b.last = 1'b0; frame_q.push_back(b);
      end
      b.d = seq ? 8'(i) : 8'($urandom); b.pl = 1'b1; b.last = 1'b0;
      frame_q.push_back(b);
    end
    for (int i = 0; i < n_tail; i++) begin
      b.d = 8'($urandom); b.pl = 1'b0; b.last = 1'b0; frame_q.push_back(b);
    end
    if (with_last && frame_q.size() > 0) begin
      b = frame_q.pop_back();
      b.last = 1'b1;
      frame_q.push_back(b);
    end
  endtask

  // Reference model.
  // 0 = no payload (ignored), 1 = short frame, 2 = good frame (fills exp_q).
  function automatic int model_kind();
    logic [7:0] pl[$];
    exp_q.delete();
    foreach (frame_q[i]) if (frame_q[i].pl) pl.push_back(frame_q[i].d);
    if (pl.size() == 0) return 0;
    if (pl.size() < NB) return 1;
    for (int i = 0; i < N; i++) exp_q.push_back({pl[2*i], pl[2*i+1]});
    return 2;
  endfunction

  task automatic drive_bytes();
    foreach (frame_q[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_tvalid    = 1'b0;
        s_tdata     = 8'($urandom);
        s_tlast     = 1'($urandom_range(0, 1));
        udp_payload = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("in_ready", 32'(s_tready), 32'd1);
      check("in_no_valid", 32'(m_valid), 32'd0);
      check("in_data_zero", 32'(m_data), 32'd0);
      check("in_last_zero", 32'(m_last), 32'd0);
      s_tvalid    = 1'b1;
      s_tdata     = frame_q[i].d;
      udp_payload = frame_q[i].pl;
      s_tlast     = frame_q[i].last;
    end
  endtask

  // Drain one frame of samples.
  // mode 0 = always ready, 1 = toggling ready, 2 = random ready.
  task automatic recv_frame(input int mode);
    int          k = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [15:0] held = '0;
    while (k < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      check("out_valid", 32'(m_valid), 32'd1);
      check("out_tready_low", 32'(s_tready), 32'd0);
      if (stalled) check("stall_hold", 32'(m_data), 32'(held));
      if (m_ready) begin
        check($sformatf("sample_%0d", k), 32'(m_data), 32'(exp_q[k]));
        check($sformatf("last_%0d", k), 32'(m_last), 32'(k == N - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = m_data;
      end
    end
    if (k < N) check("recv_timeout", 32'(k), 32'(N));
    @(negedge clk);
    m_ready = 1'b0;
    model_frames = (model_frames + 1) % 65536;
    check("done_valid", 32'(m_valid), 32'd0);
    check("done_data", 32'(m_data), 32'd0);
    check("done_last", 32'(m_last), 32'd0);
    check("done_tready", 32'(s_tready), 32'd1);
    check("frame_cnt", 32'(frame_cnt), 32'(model_frames));
  endtask

  task automatic run_frame(input int mode);
    int kind;
    drive_bytes();
    @(negedge clk);
    idle_inputs();
    kind = model_kind();
    check("valid_rise", 32'(m_valid), 32'(kind == 2));
    check("err_pulse", 32'(err_pulse), 32'(kind == 1));
    if (kind == 1 && model_errs < 255) model_errs++;
    check("err_cnt", 32'(err_cnt), 32'(model_errs));
    if (kind == 2) begin
      recv_frame(mode);
    end else begin
      @(negedge clk);
      check("err_pulse_clr", 32'(err_pulse), 32'd0);
      check("no_valid", 32'(m_valid), 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd1);
  endtask

  initial begin
    int n_hdr, n_pl, n_tail, sel;
    rst     = 1'b1;
    m_ready = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Sequential 40-byte frame: samples 0x0001, 0x0203 .. 0x2627.
    build(0, NB, 1'b1, 0, 1'b0, 1'b1);
    run_frame(0);

    // 14 header bytes ahead of the same payload.
    build(14, NB, 1'b1, 0, 1'b0, 1'b1);
    run_frame(2);

    // Lone tlast on a non-payload byte while idle is ignored.
    build(1, 0, 1'b0, 0, 1'b0, 1'b1);
    run_frame(0);

    // Short frame, then a good frame.
    build(0, 10, 1'b1, 0, 1'b0, 1'b1);
    run_frame(0);
    build(0, NB, 1'b0, 0, 1'b0, 1'b1);
    run_frame(2);

    // 44 payload bytes: the extra four are drained.
    build(0, NB + 4, 1'b1, 0, 1'b0, 1'b1);
    run_frame(0);

    // Toggling m_ready while samples are offered.
    build(2, NB, 1'b0, 0, 1'b0, 1'b1);
    run_frame(1);

    // Exact length, with tlast on a trailing header byte.
    build(0, NB, 1'b0, 1, 1'b0, 1'b1);
    run_frame(2);

    // Reset after 20 payload bytes, then a full frame.
    build(0, 20, 1'b1, 0, 1'b0, 1'b0);
    drive_bytes();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    model_frames = 0;
    model_errs   = 0;
    @(negedge clk);
    build(0, NB, 1'b1, 0, 1'b0, 1'b1);
    run_frame(0);

    // Randomized frames: lengths, headers, interleaved junk, ready pattern.
    repeat (25) begin
      sel    = int'($urandom_range(0, 3));
      n_hdr  = int'($urandom_range(0, 3));
      n_tail = int'($urandom_range(0, 1));
      case (sel)
        0:       n_pl = int'($urandom_range(1, NB - 1));
        1:       n_pl = NB;
        2:       n_pl = NB + int'($urandom_range(1, 6));
        default: n_pl = 0;
      endcase
      if (n_pl == 0 && n_hdr == 0) n_hdr = 1;
      build(n_hdr, n_pl, 1'b0, n_tail, 1'b1, 1'b1);
      run_frame(int'($urandom_range(0, 2)));
    end

    // Error counter saturates at 255.
    repeat (260) begin
      build(0, int'($urandom_range(1, 4)), 1'b0, 0, 1'b0, 1'b1);
      run_frame(0);
    end
    build(0, NB, 1'b0, 0, 1'b0, 1'b1);
    run_frame(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
